conv_code_ctrl: RTL and testbench

Sequencer in front of the convolutional encoder in the OFDM data modem. For each frame it serialises, LSB first:
- the 24-bit SIGNAL field, with the signal flag high;
- the scrambled PSDU bytes;
- 6 zero tail bits;
- zero pad bits up to a whole number of data OFDM symbols.

It produces the encoder's bit/enable/flag inputs, honours backpressure from downstream, and never drops or duplicates a bit.

---
 rtl/conv_code_ctrl_pkg.sv | 20 ++
 rtl/conv_code_ctrl_if.sv | 11 +
 rtl/conv_byte_ser.sv | 49 ++++
 rtl/conv_code_ctrl.sv | 173 +++++++++++++++++
 tb/tb_conv_code_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_code_ctrl_pkg.sv
// Shared constants and state encoding for the convolutional-encoder sequencer.
// Also lists the data-bits-per-symbol values the modem's rate table can produce.
package conv_code_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIG,
        ST_DATA,
        ST_TAIL,
        ST_PAD,
        ST_FIN
    } state_t;

    localparam int SIG_BITS  = 24;
    localparam int TAIL_BITS = 6;

    localparam int N_RATES = 8;
    localparam int NDBPS_TABLE [N_RATES] = '{24, 36, 48, 72, 96, 144, 192, 216};

endpackage

// File: rtl/conv_code_ctrl_if.sv
// PSDU byte stream into the sequencer: valid/ready handshake, one byte per transfer.
interface conv_code_ctrl_if;

    logic [7:0] byte_din;
    logic       byte_vld;
    logic       byte_rdy;

    modport master (output byte_din, output byte_vld, input byte_rdy);
    modport slave  (input byte_din, input byte_vld, output byte_rdy);

endinterface

// File: rtl/conv_byte_ser.sv
// Byte holding register and LSB-first serialiser. A byte arriving into an empty
// holder is usable in the same cycle, so byte boundaries never cost a bubble.
module conv_byte_ser (
    input  logic             din_clk,
    input  logic             rst,
    input  logic             active,
    input  logic             more,
    input  logic             enc_rdy,
    conv_code_ctrl_if.slave  byte_if,
    output logic             take,
    output logic             bit_vld,
    output logic             bit_out
);

    logic [7:0] hold;
    logic [2:0] idx;
    logic       empty;
    logic       adv_hold;

    assign adv_hold = active && enc_rdy && !empty;

    // Refill either into an empty holder or while its last bit leaves this cycle.
    assign byte_if.byte_rdy = active && more && (empty || (adv_hold && idx == 3'd7));
    assign take             = byte_if.byte_vld && byte_if.byte_rdy;

    assign bit_vld = !empty || take;
    assign bit_out = empty ? byte_if.byte_din[0] : hold[idx];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge din_clk or posedge rst) begin
        if (rst) begin
            hold  <= '0;
            idx   <= '0;
            empty <= 1'b1;
        end else if (take) begin
            hold  <= byte_if.byte_din;
            empty <= 1'b0;
            // Bit 0 went straight out if the holder was empty and the encoder was ready.
            idx   <= (empty && enc_rdy) ? 3'd1 : 3'd0;
        end else if (adv_hold) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) begin
                empty <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_code_ctrl.sv
// Frame sequencer ahead of the convolutional encoder: SIGNAL field, PSDU bits,
// tail and symbol padding, serialised one bit per encoder-ready cycle.
module conv_code_ctrl
    import conv_code_ctrl_pkg::*;
#(
    parameter int LEN_W   = 12,
    parameter int NDBPS_W = 9
) (
    input  logic               din_clk,
    input  logic               rst,
    input  logic               start,
    input  logic [23:0]        sig_word,
    input  logic [LEN_W-1:0]   data_len,
    input  logic [NDBPS_W-1:0] n_dbps,
    conv_code_ctrl_if.slave    byte_if,
    input  logic               enc_rdy,
    output logic               conv_din,
    output logic               conv_en,
    output logic               sig_flag,
    output logic               busy,
    output logic               done
);

    localparam int BIT_W = LEN_W + 3;

    state_t             state;
    logic [23:0]        sig_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   taken;
    logic [NDBPS_W-1:0] ndbps_q;
    logic [NDBPS_W-1:0] sym_cnt;
    logic [NDBPS_W-1:0] sym_nxt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   data_last;

    logic in_data;
    logic more;
    logic ser_take;
    logic ser_vld;
    logic ser_bit;
    logic emit;
    logic bit_val;

    assign in_data   = (state == ST_DATA);
    assign more      = (taken < len_q);
    assign data_last = {len_q, 3'b000} - BIT_W'(1);
    assign sym_nxt   = (sym_cnt == ndbps_q - NDBPS_W'(1)) ? '0 : sym_cnt + NDBPS_W'(1);

    conv_byte_ser u_ser (
        .din_clk (din_clk),
        .rst     (rst),
        .active  (in_data),
        .more    (more),
        .enc_rdy (enc_rdy),
        .byte_if (byte_if),
        .take    (ser_take),
        .bit_vld (ser_vld),
        .bit_out (ser_bit)
    );

    always_comb begin
        // NOTE: defaults first so no branch leaves these unassigned and no latch is inferred.
        emit    = 1'b0;
        bit_val = 1'b0;
        case (state)
            ST_SIG: begin
                emit    = enc_rdy;
                bit_val = sig_q[0];
            end
            ST_DATA: begin
                emit    = enc_rdy && ser_vld;
                bit_val = ser_bit;
            end
            ST_TAIL, ST_PAD: emit = enc_rdy;
            default: ;
        endcase
    end

    always_ff @(posedge din_clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sig_q    <= '0;
            len_q    <= '0;
            taken    <= '0;
            ndbps_q  <= '0;
            sym_cnt  <= '0;
            bit_cnt  <= '0;
            conv_din <= 1'b0;
            conv_en  <= 1'b0;
            sig_flag <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            conv_en  <= emit;
            conv_din <= emit && bit_val;
            sig_flag <= emit && (state == ST_SIG);

            if (ser_take) begin
                taken <= taken + LEN_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sig_q   <= sig_word;
                        len_q   <= data_len;
                        ndbps_q <= n_dbps;
                        taken   <= '0;
                        bit_cnt <= '0;
                        sym_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SIG;
                    end
                end
                ST_SIG: begin
                    if (emit) begin
                        sig_q <= sig_q >> 1;
                        if (bit_cnt == BIT_W'(SIG_BITS - 1)) begin
                            bit_cnt <= '0;
                            sym_cnt <= '0;
                            state   <= (len_q != '0) ? ST_DATA : ST_TAIL;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (emit) begin
                        sym_cnt <= sym_nxt;
                        if (bit_cnt == data_last) begin
                            bit_cnt <= '0;
                            state   <= ST_TAIL;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_TAIL: begin
                    if (emit) begin
                        sym_cnt <= sym_nxt;
                        if (bit_cnt == BIT_W'(TAIL_BITS - 1)) begin
                            bit_cnt <= '0;
                            // A tail landing exactly on a symbol boundary needs no padding.
                            state   <= (sym_nxt == '0 || ndbps_q == '0) ? ST_FIN : ST_PAD;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_PAD: begin
                    if (emit) begin
                        sym_cnt <= sym_nxt;
                        if (sym_nxt == '0) begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    // busy stays high through the done cycle so a coincident start is ignored.
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_code_ctrl.sv
// Self-checking bench: randomized backpressure and byte gaps against a frame model
// built from the framing rules (SIGNAL, PSDU LSB-first, tail, pad to symbol).
module tb_conv_code_ctrl;
    import conv_code_ctrl_pkg::*;

    localparam int LEN_W   = 12;
    localparam int NDBPS_W = 9;

    logic               din_clk  = 1'b0;
    logic               rst      = 1'b1;
    logic               start    = 1'b0;
    logic [23:0]        sig_word = '0;
    logic [LEN_W-1:0]   data_len = '0;
    logic [NDBPS_W-1:0] n_dbps   = '0;
    logic               enc_rdy  = 1'b0;
    logic               conv_din;
    logic               conv_en;
    logic               sig_flag;
    logic               busy;
    logic               done;

    conv_code_ctrl_if bus ();

    conv_code_ctrl #(.LEN_W(LEN_W), .NDBPS_W(NDBPS_W)) dut (
        .din_clk  (din_clk),
        .rst      (rst),
        .start    (start),
        .sig_word (sig_word),
        .data_len (data_len),
        .n_dbps   (n_dbps),
        .byte_if  (bus),
        .enc_rdy  (enc_rdy),
        .conv_din (conv_din),
        .conv_en  (conv_en),
        .sig_flag (sig_flag),
        .busy     (busy),
        .done     (done)
    );

    always #8 din_clk = ~din_clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:4095];
    int   cur_len;
    int   byte_idx;
    logic got_bits [$];
    logic got_flags [$];
    int   cyc;
    int   start_cyc;
    int   first_en;
    int   last_en;
    int   done_cnt;
    int   done_cyc;
    int   gate_err;
    int   rdy_err;

    function automatic bit hit(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    // One clock: drive inputs, note the byte transfer mid-cycle, observe registered outputs after the edge.
    task automatic drive_cycle(input bit st, input bit er, input bit bv);
        bit xfer;
        start        = st;
        enc_rdy      = er;
        bus.byte_vld = bv && (byte_idx < cur_len);
        bus.byte_din = (byte_idx < cur_len) ? mem[byte_idx] : 8'h00;
        @(negedge din_clk);
        xfer = bus.byte_vld && bus.byte_rdy;
        if (bus.byte_rdy && byte_idx >= cur_len) rdy_err++;
        @(posedge din_clk);
        #1;
        cyc++;
        if (xfer) byte_idx++;
        if (conv_en) begin
            got_bits.push_back(conv_din);
            got_flags.push_back(sig_flag);
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if (!er) gate_err++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        start = 1'b0;
    endtask

    task automatic clear_obs(input int len);
        cur_len  = len;
        byte_idx = 0;
        got_bits.delete();
        got_flags.delete();
        first_en = -1;
        last_en  = -1;
        done_cnt = 0;
        done_cyc = -1;
        gate_err = 0;
        rdy_err  = 0;
    endtask

    task automatic run_frame(input string name, input logic [23:0] sig, input int len,
                             input int ndbps, input int er_pct, input int bv_pct,
                             input bit mid_start, input bit fixed_bytes);
        logic exp_bits [$];
        logic exp_flags [$];
        int   total, pad, budget, n, mism, first_bad;
        clear_obs(len);
        for (int i = 0; i < len; i++) mem[i] = 8'($urandom_range(0, 255));
        if (fixed_bytes) begin
            mem[0] = 8'hA5;
            mem[1] = 8'h01;
            mem[2] = 8'hFF;
        end
        for (int i = 0; i < SIG_BITS; i++) begin
            exp_bits.push_back(sig[i]);
            exp_flags.push_back(1'b1);
        end
        for (int k = 0; k < len; k++) begin
            for (int b = 0; b < 8; b++) begin
                exp_bits.push_back(mem[k][b]);
                exp_flags.push_back(1'b0);
            end
        end
        total = 8 * len + TAIL_BITS;
        pad   = (ndbps == 0) ? 0 : ((total + ndbps - 1) / ndbps) * ndbps - total;
        repeat (TAIL_BITS + pad) begin
            exp_bits.push_back(1'b0);
            exp_flags.push_back(1'b0);
        end
        budget = 40 + exp_bits.size() * ((er_pct < 100 || bv_pct < 100) ? 20 : 2);

        sig_word = sig;
        data_len = LEN_W'(len);
        n_dbps   = NDBPS_W'(ndbps);
        drive_cycle(1'b1, hit(er_pct), hit(bv_pct));
        start_cyc = cyc;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_start got=%b exp=1", name, busy);
        end
        // Scramble the frame inputs to show they were latched at start.
        sig_word = 24'($urandom);
        data_len = LEN_W'($urandom);
        n_dbps   = NDBPS_W'($urandom);

        n = 0;
        while (done_cnt == 0 && n < budget) begin
            drive_cycle(mid_start && n == 30, hit(er_pct), hit(bv_pct));
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL %s done_timeout got=no_done exp=done within %0d cycles", name, budget);
        end
        checks++;
        if (got_bits.size() != exp_bits.size()) begin
            failures++;
            $display("FAIL %s emission_count got=%0d exp=%0d", name, got_bits.size(), exp_bits.size());
        end
        mism = 0;
        first_bad = -1;
        for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++) begin
            if (got_bits[i] !== exp_bits[i] || got_flags[i] !== exp_flags[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL %s bit_sequence got=%0d mismatching bits (first at %0d: bit=%b flag=%b) exp=%b/%b",
                     name, mism, first_bad, got_bits[first_bad], got_flags[first_bad],
                     exp_bits[first_bad], exp_flags[first_bad]);
        end
        checks++;
        if (gate_err != 0) begin
            failures++;
            $display("FAIL %s conv_en_without_enc_rdy got=%0d exp=0", name, gate_err);
        end
        checks++;
        if (rdy_err != 0) begin
            failures++;
            $display("FAIL %s byte_rdy_beyond_len got=%0d exp=0", name, rdy_err);
        end
        checks++;
        if (done_cyc != last_en + 1) begin
            failures++;
            $display("FAIL %s done_timing got=cycle %0d exp=cycle %0d", name, done_cyc, last_en + 1);
        end
        checks++;
        if (first_en <= start_cyc) begin
            failures++;
            $display("FAIL %s first_bit_latency got=cycle %0d exp=after %0d", name, first_en, start_cyc);
        end
        // A start coincident with done must be ignored.
        drive_cycle(1'b1, 1'b1, 1'b1);
        repeat (3) drive_cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b0 || done_cnt != 1 || got_bits.size() != exp_bits.size()) begin
            failures++;
            $display("FAIL %s post_frame got=busy %b done_pulses %0d bits %0d exp=busy 0 done_pulses 1 bits %0d",
                     name, busy, done_cnt, got_bits.size(), exp_bits.size());
        end
    endtask

    task automatic test_reset;
        clear_obs(0);
        rst = 1'b1;
        repeat (2) @(negedge din_clk);
        checks++;
        if ({conv_en, conv_din, sig_flag, busy, done, bus.byte_rdy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {conv_en, conv_din, sig_flag, busy, done, bus.byte_rdy});
        end
        rst = 1'b0;
        repeat (4) drive_cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if (busy !== 1'b0 || got_bits.size() != 0 || done_cnt != 0) begin
            failures++;
            $display("FAIL reset_idle got=busy %b bits %0d done %0d exp=0 0 0", busy, got_bits.size(), done_cnt);
        end
    endtask

    task automatic test_basic;
        logic [7:0] b0;
        run_frame("basic", 24'h00000B, 3, 24, 100, 100, 1'b0, 1'b1);
        checks++;
        if (got_bits.size() < 32 || {got_bits[0], got_bits[1], got_bits[2], got_bits[3], got_bits[4]} !== 5'b11010) begin
            failures++;
            $display("FAIL basic_sig_head got=%0d bits exp=1,1,0,1,0 leading", got_bits.size());
        end
        b0 = '0;
        for (int b = 0; b < 8 && 24 + b < got_bits.size(); b++) b0[b] = got_bits[24 + b];
        checks++;
        if (b0 !== 8'hA5) begin
            failures++;
            $display("FAIL basic_first_byte got=%h exp=a5", b0);
        end
        checks++;
        if (first_en != start_cyc + 1 || last_en - first_en + 1 != 72) begin
            failures++;
            $display("FAIL basic_no_gaps got=first %0d span %0d exp=first %0d span 72",
                     first_en, last_en - first_en + 1, start_cyc + 1);
        end
    endtask

    task automatic test_no_pad;
        run_frame("no_pad", 24'h00A1C3, 3, 30, 100, 100, 1'b0, 1'b0);
        checks++;
        if (got_bits.size() != 54) begin
            failures++;
            $display("FAIL no_pad_total got=%0d exp=54", got_bits.size());
        end
    endtask

    task automatic test_empty;
        run_frame("empty", 24'h03F00D, 0, 24, 100, 100, 1'b0, 1'b0);
        checks++;
        if (got_bits.size() != 48) begin
            failures++;
            $display("FAIL empty_total got=%0d exp=48", got_bits.size());
        end
    endtask

    task automatic test_stall;
        run_frame("stall", 24'h00000B, 3, 24, 55, 40, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        for (int f = 0; f < 6; f++) begin
            int nd;
            nd = (f == 5) ? 0 : NDBPS_TABLE[$urandom_range(0, N_RATES - 1)];
            run_frame($sformatf("random%0d", f), 24'($urandom_range(0, 24'h03FFFF)),
                      $urandom_range(0, 40), nd, 70, 60, 1'b0, 1'b0);
        end
    endtask

    task automatic test_busy_start_and_reset;
        int n;
        run_frame("busy_start", 24'h012345, 8, 48, 80, 80, 1'b1, 1'b0);

        clear_obs(10);
        for (int i = 0; i < 10; i++) mem[i] = 8'($urandom_range(0, 255));
        sig_word = 24'h00ABCD;
        data_len = LEN_W'(10);
        n_dbps   = NDBPS_W'(48);
        drive_cycle(1'b1, 1'b1, 1'b1);
        n = 0;
        while (got_bits.size() < 40 && n < 200) begin
            drive_cycle(1'b0, 1'b1, 1'b1);
            n++;
        end
        checks++;
        if (got_bits.size() != 40) begin
            failures++;
            $display("FAIL reset_reach40 got=%0d exp=40", got_bits.size());
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({conv_en, conv_din, sig_flag, busy, done, bus.byte_rdy} !== 6'b0) begin
            failures++;
            $display("FAIL midframe_reset_outputs got=%b exp=000000",
                     {conv_en, conv_din, sig_flag, busy, done, bus.byte_rdy});
        end
        repeat (3) drive_cycle(1'b0, 1'b1, 1'b1);
        @(negedge din_clk);
        rst = 1'b0;
        repeat (8) drive_cycle(1'b0, 1'b1, 1'b1);
        checks++;
        if (done_cnt != 0 || got_bits.size() != 40 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset_quiet got=done %0d bits %0d busy %b exp=0 40 0",
                     done_cnt, got_bits.size(), busy);
        end
        run_frame("after_reset", 24'h00BEEF, 5, 36, 75, 70, 1'b0, 1'b0);
    endtask

    task automatic test_max_len;
        run_frame("max_len", 24'h02D00B, 4095, 216, 100, 100, 1'b0, 1'b0);
    endtask

    initial begin
        cyc = 0;
        bus.byte_vld = 1'b0;
        bus.byte_din = 8'h00;
        test_reset();
        test_basic();
        test_no_pad();
        test_empty();
        test_stall();
        test_random();
        test_busy_start_and_reset();
        test_max_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
